sram_1p_march_bist: RTL and testbench
=====================================

SRAM_1P_MARCH_BIST -- requirements
Module: sram_1p_march_bist

Interface
REQ-001 SHALL have parameter NumWords, default 256: array depth; legal range >= 2.
REQ-002 SHALL have parameter DataWidth, default 64: word width; legal range >= 1.
REQ-003 SHALL have localparam AddrWidth = max(1, clog2(NumWords)).
REQ-004 SHALL have one clock and an asynchronous active-low reset.
REQ-005 clk_i  in  1: clock; all state updates on its rising edge.
REQ-006 rst_ni  in  1: reset; asynchronous, active-low.
REQ-007 req_i  in  1: functional access request.
REQ-008 we_i  in  1: 1 = write, 0 = read.
REQ-009 addr_i  in  AddrWidth: word address.
REQ-010 wdata_i  in  DataWidth: write data.
REQ-011 bm_i  in  DataWidth: per-bit write mask; 1 = bit written.
REQ-012 gnt_o  out  1: request accepted this cycle.
REQ-013 rdata_o  out  DataWidth: read data.
REQ-014 bist_start_i  in  1: starts a March C- run.
REQ-015 bist_busy_o  out  1: run in progress.
REQ-016 bist_done_o  out  1: run finished; sticky.
REQ-017 bist_fail_o  out  1: at least one mismatch; sticky.
REQ-018 bist_fail_addr_o  out  AddrWidth: address of the first mismatch.

Function
REQ-019 Array SHALL be NumWords x DataWidth flops or latches with no reset; after power-up its contents are X.
REQ-020 In IDLE, gnt_o SHALL equal req_i.
REQ-021 Outside IDLE, gnt_o SHALL be 0 and functional requests SHALL have no effect.
REQ-022 Granted write: word[addr] <= (word & ~bm_i) | (wdata_i & bm_i).
REQ-023 Granted read: rdata_o SHALL present word[addr] on the cycle after the grant, i.e. one-cycle latency.
REQ-024 rdata_o SHALL hold its value when no read is granted, including throughout BIST.
REQ-025 An out-of-range address (addr_i >= NumWords) SHALL make a write a no-op and make a read return all-X.
REQ-026 FSM states, IDLE -> RUN -> IDLE; RUN steps through elements E0..E5 in order:
  E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0).
REQ-027 "up" SHALL count 0..NumWords-1 and "down" SHALL count NumWords-1..0; each op takes one cycle.
REQ-028 BIST writes SHALL use a full mask; pattern 0 = all-zeros and pattern 1 = all-ones.
REQ-029 BIST reads SHALL be compared one cycle after issue (pipelined); the compare of the last read of an element overlaps the first op of the next element.
REQ-030 bist_start_i SHALL be sampled only in IDLE; it is ignored while busy.
REQ-031 If bist_start_i and req_i are both high in IDLE, the functional access SHALL be granted and the run SHALL begin the next cycle.
REQ-032 On start acceptance, bist_done_o and bist_fail_o SHALL clear and bist_busy_o SHALL rise the next cycle.
REQ-033 bist_busy_o SHALL stay high for exactly 10*NumWords+1 cycles (+1 for the final compare).
REQ-034 On the cycle after busy falls, bist_done_o SHALL be 1 and SHALL hold until the next accepted start or reset.
REQ-035 First mismatch: bist_fail_o <= 1 and bist_fail_addr_o <= address of the failing read.
REQ-036 Later mismatches SHALL NOT update bist_fail_addr_o; the run always completes and never aborts early.
REQ-037 A compare against an X read value SHALL count as a mismatch.
REQ-038 BIST is destructive; after a run every word SHALL read 0.

Reset
REQ-039 rst_ni low SHALL immediately force: FSM IDLE, gnt_o follows req_i, rdata_o=0, bist_busy_o=0, bist_done_o=0, bist_fail_o=0, bist_fail_addr_o=0, and clear all counters.
REQ-040 Reset mid-run SHALL abort the run with no done pulse; array contents are then undefined, and the run restarts only on a new bist_start_i.

Verification
REQ-041 Write/read: NumWords=16, DataWidth=8; write 0xA5 @3, then read @3 -> rdata_o=0xA5 one cycle after grant.
REQ-042 Mask: write 0xFF @5, then write 0x00 with bm=0x0F, then read -> 0xF0.
REQ-043 Clean BIST: NumWords=16, pulse start -> busy high 161 cycles, done=1, fail=0, all words read 0 afterwards.
REQ-044 Fault: bench forces bit 2 of word 9 stuck-at-1 -> done=1, fail=1, fail_addr=9, busy length unchanged (161).
REQ-045 Arbitration: req_i high during the run -> gnt_o=0 and memory unchanged by it; start re-pulsed mid-run is ignored.
REQ-046 Reset at cycle 50 of a run -> all BIST outputs 0 at once; new start -> full 161-cycle run, done=1.

Source files
------------

// File: rtl/sram_1p_march_bist.sv
// Single-port word-addressed SRAM model with a bit-masked write port and a built-in
// March C- self test that shares the array port with functional traffic.
module sram_1p_march_bist #(
  parameter int NumWords  = 256,
  parameter int DataWidth = 64,
  localparam int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [DataWidth-1:0] bm_i,
  output logic                 gnt_o,
  output logic [DataWidth-1:0] rdata_o,
  input  logic                 bist_start_i,
  output logic                 bist_busy_o,
  output logic                 bist_done_o,
  output logic                 bist_fail_o,
  output logic [AddrWidth-1:0] bist_fail_addr_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

  state_e                              state_q, state_d;
  logic [2:0]                          elem_q;
  logic                                op_q;
  logic [AddrWidth-1:0]                baddr_q;
  logic [NumWords-1:0][DataWidth-1:0]  mem;

  logic                 start_acc, in_range;
  logic                 two_op, down, last_op, last_addr, run_end;
  logic                 b_we, b_re;
  logic [DataWidth-1:0] b_wval, b_rexp;

  logic                 mem_we;
  logic [AddrWidth-1:0] mem_addr;
  logic [DataWidth-1:0] mem_wdata, mem_bm;

  logic                 vld_p1, mismatch;
  logic [DataWidth-1:0] rd_p1, exp_p1;
  logic [AddrWidth-1:0] caddr_p1;

  assign start_acc   = (state_q == IDLE) && bist_start_i;
  assign gnt_o       = (state_q == IDLE) && req_i;
  assign bist_busy_o = (state_q != IDLE);
  assign in_range    = {1'b0, addr_i} < (AddrWidth + 1)'(NumWords);

  // March element decode: two-op elements read the old pattern then write its complement.
  always_comb begin
    b_we   = 1'b0;
    b_re   = 1'b0;
    b_wval = '0;
    b_rexp = '0;
    two_op = 1'b0;
    case (elem_q)
      3'd0: b_we = 1'b1;
      3'd1, 3'd3: begin
        two_op = 1'b1;
        if (op_q) begin
          b_we   = 1'b1;
          b_wval = '1;
        end else begin
          b_re = 1'b1;
        end
      end
      3'd2, 3'd4: begin
        two_op = 1'b1;
        if (op_q) begin
          b_we = 1'b1;
        end else begin
          b_re   = 1'b1;
          b_rexp = '1;
        end
      end
      default: b_re = 1'b1;
    endcase
  end

  assign down      = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign last_op   = !two_op || op_q;
  assign last_addr = down ? (baddr_q == '0) : (baddr_q == LastAddr);
  assign run_end   = (elem_q == 3'd5) && last_addr;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bist_start_i) state_d = RUN;
      RUN:     if (run_end) state_d = DRAIN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      elem_q  <= '0;
      op_q    <= 1'b0;
      baddr_q <= '0;
    end else if (start_acc) begin
      elem_q  <= '0;
      op_q    <= 1'b0;
      baddr_q <= '0;
    end else if (state_q == RUN) begin
      if (!last_op) begin
        op_q <= 1'b1;
      end else begin
        op_q <= 1'b0;
        if (!last_addr) begin
          baddr_q <= down ? baddr_q - AddrWidth'(1) : baddr_q + AddrWidth'(1);
        end else begin
          elem_q  <= elem_q + 3'd1;
          baddr_q <= ((elem_q == 3'd2) || (elem_q == 3'd3)) ? LastAddr : '0;
        end
      end
    end
  end

  // Array port mux: the BIST owns the port for the whole run.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr_i;
    mem_wdata = wdata_i;
    mem_bm    = bm_i;
    if (state_q == RUN) begin
      mem_we    = b_we;
      mem_addr  = baddr_q;
      mem_wdata = b_wval;
      mem_bm    = '1;
    end else if (gnt_o && we_i && in_range) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_addr] <= (mem[mem_addr] & ~mem_bm) | (mem_wdata & mem_bm);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               rdata_o <= '0;
    else if (gnt_o && !we_i)   rdata_o <= in_range ? mem[addr_i] : {DataWidth{1'bx}};
  end

  // Stage p1: BIST read data captured alongside its expected pattern and address.
  always_ff @(posedge clk_i) begin
    rd_p1    <= mem[baddr_q];
    exp_p1   <= b_rexp;
    caddr_p1 <= baddr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) vld_p1 <= 1'b0;
    else         vld_p1 <= (state_q == RUN) && b_re;
  end

  // Written so that an unknown read value falls through to a mismatch.
  always_comb begin
    mismatch = 1'b1;
    if (rd_p1 == exp_p1) mismatch = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bist_done_o      <= 1'b0;
      bist_fail_o      <= 1'b0;
      bist_fail_addr_o <= '0;
    end else if (start_acc) begin
      bist_done_o <= 1'b0;
      bist_fail_o <= 1'b0;
    end else begin
      if (state_q == DRAIN) bist_done_o <= 1'b1;
      if (vld_p1 && mismatch && !bist_fail_o) begin
        bist_fail_o      <= 1'b1;
        bist_fail_addr_o <= caddr_p1;
      end
    end
  end

endmodule

// File: tb/tb_sram_1p_march_bist.sv
// Randomized, model-checked bench for the 16x8 configuration of sram_1p_march_bist.
module tb_sram_1p_march_bist;

  localparam int NW = 16;
  localparam int DW = 8;
  localparam int RUN_LEN = 10 * NW + 1;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          req_i = 1'b0;
  logic          we_i = 1'b0;
  logic [3:0]    addr_i = '0;
  logic [DW-1:0] wdata_i = '0;
  logic [DW-1:0] bm_i = '0;
  logic          gnt_o;
  logic [DW-1:0] rdata_o;
  logic          bist_start_i = 1'b0;
  logic          bist_busy_o;
  logic          bist_done_o;
  logic          bist_fail_o;
  logic [3:0]    bist_fail_addr_o;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model [NW];

  sram_1p_march_bist #(.NumWords(NW), .DataWidth(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .bm_i(bm_i), .gnt_o(gnt_o), .rdata_o(rdata_o),
    .bist_start_i(bist_start_i), .bist_busy_o(bist_busy_o), .bist_done_o(bist_done_o),
    .bist_fail_o(bist_fail_o), .bist_fail_addr_o(bist_fail_addr_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic wr(input logic [3:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d; bm_i = m;
    step();
    req_i = 1'b0; we_i = 1'b0;
    model[a] = (model[a] & ~m) | (d & m);
  endtask

  task automatic rd(input logic [3:0] a, output logic [DW-1:0] q);
    req_i = 1'b1; we_i = 1'b0; addr_i = a;
    step();
    req_i = 1'b0;
    q = rdata_o;
  endtask

  task automatic run_bist(output int n);
    bist_start_i = 1'b1;
    step();
    bist_start_i = 1'b0;
    n = 0;
    while (bist_busy_o && n < 2000) begin
      n++;
      step();
    end
    for (int i = 0; i < NW; i++) model[i] = '0;
  endtask

  task automatic test_reset();
    req_i = 1'b1;
    #1;
    checks++;
    if (gnt_o !== 1'b1) begin errors++; $display("FAIL reset_gnt got %b want 1", gnt_o); end
    checks++;
    if ({bist_busy_o, bist_done_o, bist_fail_o, bist_fail_addr_o, rdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b fail=%b addr=%0d rdata=%h want all 0",
               bist_busy_o, bist_done_o, bist_fail_o, bist_fail_addr_o, rdata_o);
    end
    req_i = 1'b0;
    step();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    logic [DW-1:0] q;
    wr(4'd3, 8'hA5, 8'hFF);
    rd(4'd3, q);
    checks++;
    if (q !== 8'hA5) begin errors++; $display("FAIL write_read got %h want a5", q); end
    step();
    checks++;
    if (rdata_o !== 8'hA5) begin errors++; $display("FAIL rdata_hold got %h want a5", rdata_o); end
  endtask

  task automatic test_mask();
    logic [DW-1:0] q;
    wr(4'd5, 8'hFF, 8'hFF);
    wr(4'd5, 8'h00, 8'h0F);
    rd(4'd5, q);
    checks++;
    if (q !== 8'hF0) begin errors++; $display("FAIL mask got %h want f0", q); end
  endtask

  task automatic check_all_zero(input string tag);
    logic [DW-1:0] q;
    for (int a = 0; a < NW; a++) begin
      rd(4'(a), q);
      checks++;
      if (q !== 8'h00) begin errors++; $display("FAIL %s word %0d got %h want 00", tag, a, q); end
    end
  endtask

  task automatic test_bist_clean();
    int n;
    run_bist(n);
    checks++;
    if (n != RUN_LEN) begin errors++; $display("FAIL clean_busy_len got %0d want %0d", n, RUN_LEN); end
    checks++;
    if ({bist_done_o, bist_fail_o} !== 2'b10) begin
      errors++; $display("FAIL clean_status got done=%b fail=%b want done=1 fail=0", bist_done_o, bist_fail_o);
    end
    step();
    checks++;
    if (bist_done_o !== 1'b1) begin errors++; $display("FAIL done_sticky got %b want 1", bist_done_o); end
    check_all_zero("clean_zero");
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_rd;
    logic r, w;
    logic [3:0] a;
    logic [DW-1:0] d, m;
    exp_rd = rdata_o;
    for (int i = 0; i < 80; i++) begin
      r = 1'($urandom); w = 1'($urandom); a = 4'($urandom_range(0, NW - 1));
      d = 8'($urandom); m = 8'($urandom);
      req_i = r; we_i = w; addr_i = a; wdata_i = d; bm_i = m;
      #1;
      checks++;
      if (gnt_o !== r) begin errors++; $display("FAIL rand_gnt cycle %0d got %b want %b", i, gnt_o, r); end
      if (r && w) model[a] = (model[a] & ~m) | (d & m);
      if (r && !w) exp_rd = model[a];
      step();
      checks++;
      if (rdata_o !== exp_rd) begin
        errors++; $display("FAIL rand_rdata cycle %0d got %h want %h", i, rdata_o, exp_rd);
      end
    end
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic test_fault();
    int n;
    force dut.mem[9][2] = 1'b1;
    run_bist(n);
    release dut.mem[9][2];
    checks++;
    if (n != RUN_LEN) begin errors++; $display("FAIL fault_busy_len got %0d want %0d", n, RUN_LEN); end
    checks++;
    if ({bist_done_o, bist_fail_o} !== 2'b11) begin
      errors++; $display("FAIL fault_status got done=%b fail=%b want 1 1", bist_done_o, bist_fail_o);
    end
    checks++;
    if (bist_fail_addr_o !== 4'd9) begin
      errors++; $display("FAIL fault_addr got %0d want 9", bist_fail_addr_o);
    end
    wr(4'd9, 8'h00, 8'hFF);
  endtask

  task automatic test_arbitration();
    logic [DW-1:0] q;
    int n;
    int bad_gnt, bad_hold;
    wr(4'd3, 8'h3C, 8'hFF);
    rd(4'd3, q);
    bist_start_i = 1'b1;
    step();
    bist_start_i = 1'b0;
    n = 0; bad_gnt = 0; bad_hold = 0;
    while (bist_busy_o && n < 2000) begin
      n++;
      req_i = 1'b1; we_i = 1'($urandom); addr_i = 4'd3; wdata_i = 8'h55; bm_i = 8'hFF;
      bist_start_i = (n == 30 || n == 100);
      #1;
      if (gnt_o !== 1'b0) bad_gnt++;
      if (rdata_o !== 8'h3C) bad_hold++;
      step();
    end
    req_i = 1'b0; we_i = 1'b0; bist_start_i = 1'b0;
    for (int i = 0; i < NW; i++) model[i] = '0;
    checks++;
    if (bad_gnt != 0) begin errors++; $display("FAIL arb_gnt got %0d granted cycles want 0", bad_gnt); end
    checks++;
    if (bad_hold != 0) begin errors++; $display("FAIL arb_rdata_hold got %0d changed cycles want 0", bad_hold); end
    checks++;
    if (n != RUN_LEN) begin errors++; $display("FAIL arb_busy_len got %0d want %0d", n, RUN_LEN); end
    checks++;
    if ({bist_done_o, bist_fail_o} !== 2'b10) begin
      errors++; $display("FAIL arb_status got done=%b fail=%b want 1 0", bist_done_o, bist_fail_o);
    end
    rd(4'd3, q);
    checks++;
    if (q !== 8'h00) begin errors++; $display("FAIL arb_mem got %h want 00", q); end
  endtask

  task automatic test_reset_midrun();
    logic [DW-1:0] q;
    int n;
    wr(4'd7, 8'h81, 8'hFF);
    rd(4'd7, q);
    force dut.mem[9][2] = 1'b1;
    bist_start_i = 1'b1;
    step();
    bist_start_i = 1'b0;
    repeat (49) step();
    release dut.mem[9][2];
    checks++;
    if ({bist_busy_o, bist_fail_o, bist_fail_addr_o} !== {1'b1, 1'b1, 4'd9}) begin
      errors++; $display("FAIL midrun_pre got busy=%b fail=%b addr=%0d want 1 1 9",
                         bist_busy_o, bist_fail_o, bist_fail_addr_o);
    end
    rst_ni = 1'b0;
    req_i = 1'b1;
    #1;
    checks++;
    if ({bist_busy_o, bist_done_o, bist_fail_o, bist_fail_addr_o, rdata_o} !== '0) begin
      errors++;
      $display("FAIL midrun_reset got busy=%b done=%b fail=%b addr=%0d rdata=%h want all 0",
               bist_busy_o, bist_done_o, bist_fail_o, bist_fail_addr_o, rdata_o);
    end
    checks++;
    if (gnt_o !== 1'b1) begin errors++; $display("FAIL midrun_reset_gnt got %b want 1", gnt_o); end
    req_i = 1'b0;
    step();
    rst_ni = 1'b1;
    repeat (3) step();
    checks++;
    if ({bist_busy_o, bist_done_o} !== 2'b00) begin
      errors++; $display("FAIL midrun_no_restart got busy=%b done=%b want 0 0", bist_busy_o, bist_done_o);
    end
    run_bist(n);
    checks++;
    if (n != RUN_LEN) begin errors++; $display("FAIL midrun_busy_len got %0d want %0d", n, RUN_LEN); end
    checks++;
    if ({bist_done_o, bist_fail_o} !== 2'b10) begin
      errors++; $display("FAIL midrun_status got done=%b fail=%b want 1 0", bist_done_o, bist_fail_o);
    end
    check_all_zero("midrun_zero");
  endtask

  task automatic test_back_to_back();
    int n;
    wr(4'd2, 8'h6B, 8'hFF);
    bist_start_i = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = 4'd2;
    #1;
    checks++;
    if (gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_gnt got %b want 1", gnt_o); end
    step();
    bist_start_i = 1'b0; req_i = 1'b0;
    checks++;
    if (rdata_o !== 8'h6B) begin errors++; $display("FAIL b2b_rdata got %h want 6b", rdata_o); end
    checks++;
    if ({bist_busy_o, bist_done_o, bist_fail_o} !== 3'b100) begin
      errors++; $display("FAIL b2b_start got busy=%b done=%b fail=%b want 1 0 0",
                         bist_busy_o, bist_done_o, bist_fail_o);
    end
    n = 0;
    while (bist_busy_o && n < 2000) begin
      n++;
      step();
    end
    for (int i = 0; i < NW; i++) model[i] = '0;
    checks++;
    if (n != RUN_LEN) begin errors++; $display("FAIL b2b_busy_len got %0d want %0d", n, RUN_LEN); end
    checks++;
    if (bist_done_o !== 1'b1) begin errors++; $display("FAIL b2b_done got %b want 1", bist_done_o); end
  endtask

  initial begin
    for (int i = 0; i < NW; i++) model[i] = '0;
    test_reset();
    test_write_read();
    test_mask();
    test_bist_clean();
    test_random();
    test_fault();
    test_random();
    test_arbitration();
    test_reset_midrun();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
